// File: rtl/program_sequencer.sv
// program_sequencer: fetch/decode controller for computational_unit.
// Fetches 8-bit instructions, keeps pc, emits one EXEC cycle of controls.
module program_sequencer (
  input  logic       clk,
  input  logic       async_reset_n,
  input  logic [7:0] pm_data,
  input  logic       pm_ready,
  input  logic       r_eq_0,
  output logic [7:0] pm_addr,
  output logic       pm_rd,
  output logic       cu_sync_reset,
  output logic [8:0] reg_en,
  output logic [3:0] source_sel,
  output logic [3:0] ir_nibble,
  output logic       i_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_FETCH,
    S_EXEC,
    S_OPERAND,
    S_HALT
  } state_t;

  state_t     state, state_nx;
  logic [7:0] pc, pc_nx;
  logic [7:0] ir, ir_nx;
  logic       taken, taken_nx;
  logic [7:0] pc_inc;

  assign pc_inc  = pc + 8'd1;
  assign pm_addr = pc;

  // ddd code 4 is o_reg, which lives at bit 8
  function automatic logic [8:0] dest_en(input logic [2:0] d);
    logic [8:0] r;
    r = '0;
    if (d == 3'd4) r[8] = 1'b1;
    else           r[d] = 1'b1;
    return r;
  endfunction

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state <= S_SYNC;
      pc    <= '0;
      ir    <= '0;
      taken <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
      taken <= taken_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    ir_nx         = ir;
    taken_nx      = taken;
    pm_rd         = 1'b0;
    cu_sync_reset = 1'b0;
    reg_en        = '0;
    source_sel    = '0;
    ir_nibble     = '0;
    i_sel         = 1'b0;
    x_sel         = 1'b0;
    y_sel         = 1'b0;
    halted        = 1'b0;
    unique case (state)
      S_SYNC: begin
        cu_sync_reset = 1'b1;
        state_nx      = S_FETCH;
      end
      S_FETCH: begin
        pm_rd = 1'b1;
        if (pm_ready) begin
          ir_nx    = pm_data;
          pc_nx    = pc_inc;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nx = S_FETCH;
        unique case (1'b1)
          !ir[7]: begin
            source_sel = 4'd8;
            ir_nibble  = ir[3:0];
            reg_en     = dest_en(ir[6:4]);
          end
          ir[7:6] == 2'b10: begin
            source_sel = {1'b0, ir[2:0]};
            reg_en     = dest_en(ir[5:3]);
            i_sel      = (ir == 8'hB6);
          end
          ir[7:5] == 3'b110: begin
            x_sel     = ir[4];
            y_sel     = ir[3];
            ir_nibble = {1'b0, ir[2:0]};
            reg_en    = 9'h010;
          end
          ir[7:4] == 4'hE: begin
            if (ir[3:0] == 4'h0) begin
              taken_nx = 1'b1;
              state_nx = S_OPERAND;
            end else if (ir[3:0] == 4'h1) begin
              taken_nx = !r_eq_0;
              state_nx = S_OPERAND;
            end else if (ir[3:0] == 4'h2) begin
              taken_nx = r_eq_0;
              state_nx = S_OPERAND;
            end
          end
          ir[7:3] == 5'b11110: begin
            source_sel = 4'd9;
            reg_en     = dest_en(ir[2:0]);
          end
          default: begin
            if (ir == 8'hFF) state_nx = S_HALT;
          end
        endcase
      end
      S_OPERAND: begin
        pm_rd = 1'b1;
        if (pm_ready) begin
          pc_nx    = taken ? pm_data : pc_inc;
          state_nx = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nx = S_SYNC;
      end
    endcase
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a program-memory model
// and a queue of expected per-instruction fetch/EXEC results.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       async_reset_n;
  logic [7:0] pm_data;
  logic       pm_ready;
  logic       r_eq_0;
  logic [7:0] pm_addr;
  logic       pm_rd;
  logic       cu_sync_reset;
  logic [8:0] reg_en;
  logic [3:0] source_sel;
  logic [3:0] ir_nibble;
  logic       i_sel, x_sel, y_sel;
  logic       halted;

  logic [7:0] mem [256];
  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [7:0] addr;
    logic       jump;
    logic [8:0] en;
    logic [3:0] src;
    logic [3:0] nib;
    logic [2:0] sel;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign pm_data = mem[pm_addr];

  program_sequencer dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .pm_data       (pm_data),
    .pm_ready      (pm_ready),
    .r_eq_0        (r_eq_0),
    .pm_addr       (pm_addr),
    .pm_rd         (pm_rd),
    .cu_sync_reset (cu_sync_reset),
    .reg_en        (reg_en),
    .source_sel    (source_sel),
    .ir_nibble     (ir_nibble),
    .i_sel         (i_sel),
    .x_sel         (x_sel),
    .y_sel         (y_sel),
    .halted        (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] addr,
                      input logic jump, input logic [8:0] en,
                      input logic [3:0] src, input logic [3:0] nib,
                      input logic [2:0] sel);
    exp_t e;
    e.tag  = tag;
    e.addr = addr;
    e.jump = jump;
    e.en   = en;
    e.src  = src;
    e.nib  = nib;
    e.sel  = sel;
    sb.push_back(e);
  endtask

  // Called at a FETCH negedge; leaves at the negedge of the next FETCH
  task automatic run_insn();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_rd"}, pm_rd, 1'b1);
    chk({e.tag, "_addr"}, pm_addr, e.addr);
    @(negedge clk);
    chk({e.tag, "_en"}, reg_en, e.en);
    chk({e.tag, "_src"}, source_sel, e.src);
    chk({e.tag, "_nib"}, ir_nibble, e.nib);
    chk({e.tag, "_sel"}, {i_sel, x_sel, y_sel}, e.sel);
    @(negedge clk);
    if (e.jump) begin
      chk({e.tag, "_op_addr"}, pm_addr, e.addr + 8'd1);
      chk({e.tag, "_op_en"}, reg_en, 9'h000);
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hE3;
    mem[8'h00] = 8'h05; mem[8'h01] = 8'hD2;
    mem[8'h02] = 8'hB6; mem[8'h03] = 8'hA4;
    mem[8'h04] = 8'hE0; mem[8'h05] = 8'h10;
    mem[8'h10] = 8'hE1; mem[8'h11] = 8'h40;
    mem[8'h40] = 8'hE0; mem[8'h41] = 8'h10;
    mem[8'h12] = 8'hE0; mem[8'h13] = 8'hFE;
    mem[8'hFE] = 8'hE0; mem[8'hFF] = 8'h20;
    mem[8'h20] = 8'hF3; mem[8'h21] = 8'hE3;
    mem[8'h22] = 8'hE0; mem[8'h23] = 8'hFE;

    push("ldi",      8'h00, 0, 9'h001, 4'd8, 4'd5, 3'b000);
    push("alu",      8'h01, 0, 9'h010, 4'd0, 4'd2, 3'b010);
    push("imov",     8'h02, 0, 9'h040, 4'd6, 4'd0, 3'b100);
    push("mov",      8'h03, 0, 9'h100, 4'd4, 4'd0, 3'b000);
    push("jmp10",    8'h04, 1, 9'h000, 4'd0, 4'd0, 3'b000);
    push("jnz_t",    8'h10, 1, 9'h000, 4'd0, 4'd0, 3'b000);
    push("jmp_back", 8'h40, 1, 9'h000, 4'd0, 4'd0, 3'b000);
    push("jnz_nt",   8'h10, 1, 9'h000, 4'd0, 4'd0, 3'b000);
    push("jmpfe",    8'h12, 1, 9'h000, 4'd0, 4'd0, 3'b000);
    push("jmp_ff",   8'hFE, 1, 9'h000, 4'd0, 4'd0, 3'b000);
    push("pins",     8'h20, 0, 9'h008, 4'd9, 4'd0, 3'b000);
    push("nop",      8'h21, 0, 9'h000, 4'd0, 4'd0, 3'b000);
    push("jmpfe2",   8'h22, 1, 9'h000, 4'd0, 4'd0, 3'b000);
    push("jz_wrap",  8'hFE, 1, 9'h000, 4'd0, 4'd0, 3'b000);
    push("halt",     8'h00, 0, 9'h000, 4'd0, 4'd0, 3'b000);

    async_reset_n = 1'b0;
    pm_ready      = 1'b1;
    r_eq_0        = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_sync", cu_sync_reset, 1'b1);
      chk("rst_rd", pm_rd, 1'b0);
      chk("rst_halt", halted, 1'b0);
      chk("rst_addr", pm_addr, 8'h00);
      chk("rst_en", reg_en, 9'h000);
    end
    async_reset_n = 1'b1;
    #1;
    chk("sync_after_rel", cu_sync_reset, 1'b1);
    chk("rd_after_rel", pm_rd, 1'b0);
    @(negedge clk);
    chk("sync_drop", cu_sync_reset, 1'b0);
    chk("halt_low", halted, 1'b0);

    repeat (6) run_insn();
    r_eq_0 = 1'b1;
    repeat (4) run_insn();
    r_eq_0 = 1'b0;
    run_insn();

    // stall during FETCH of 0x21
    pm_ready = 1'b0;
    repeat (3) begin
      chk("stall_rd", pm_rd, 1'b1);
      chk("stall_addr", pm_addr, 8'h21);
      chk("stall_en", reg_en, 9'h000);
      @(negedge clk);
    end
    pm_ready = 1'b1;
    run_insn();

    mem[8'hFE] = 8'hE2;
    mem[8'h00] = 8'hFF;
    run_insn();
    run_insn();
    run_insn();
    repeat (22) begin
      chk("halted", halted, 1'b1);
      chk("halt_rd", pm_rd, 1'b0);
      chk("halt_en", reg_en, 9'h000);
      @(negedge clk);
    end

    mem[8'h00] = 8'h05;
    async_reset_n = 1'b0;
    @(negedge clk);
    chk("rst2_halt", halted, 1'b0);
    async_reset_n = 1'b1;
    @(negedge clk);
    chk("rst2_fetch", pm_addr, 8'h00);
    @(negedge clk);
    chk("rst2_exec_en", reg_en, 9'h001);
    async_reset_n = 1'b0;
    #1;
    chk("async_en", reg_en, 9'h000);
    chk("async_src", source_sel, 4'd0);
    chk("async_sync", cu_sync_reset, 1'b1);
    chk("async_addr", pm_addr, 8'h00);
    @(negedge clk);
    async_reset_n = 1'b1;
    @(negedge clk);
    chk("restart_rd", pm_rd, 1'b1);
    chk("restart_addr", pm_addr, 8'h00);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
